// File: rtl/nibble_serial_adder.sv
// Multi-nibble serial adder: WIDTH = 4*NIBBLES bit a + b + cin through one 4-bit
// adder, LSB nibble first, valid/ready on both sides. Optional macro: SERIAL_ADD_OVF_EN.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [NIBBLES-1:0][3:0] a_q;
    logic [NIBBLES-1:0][3:0] b_q;
    logic [NIBBLES-1:0][3:0] sum_q;
    logic                    carry;
    logic [IDX_W-1:0]        idx;
    logic                    accept;
    logic                    last;
    logic [4:0]              nib_res;

    assign accept  = in_valid && (state == IDLE);
    assign last    = (idx == LAST_IDX);
    assign nib_res = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {4'b0000, carry};
    assign out_sum = sum_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ADD;
            end
            ADD: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out_cout <= 1'b0;
        end else if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            sum_q    <= '0;
            carry    <= in_cin;
            idx      <= '0;
            out_cout <= 1'b0;
        end else if (state == ADD) begin
            sum_q[idx] <= nib_res[3:0];
            carry      <= nib_res[4];
            idx        <= idx + IDX_W'(1);
            if (last) out_cout <= nib_res[4];
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the sign bit comes from the low three bits of the top nibble.
    logic [3:0] low3_res;
    assign low3_res = {1'b0, a_q[idx][2:0]} + {1'b0, b_q[idx][2:0]} + {3'b000, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (accept) begin
            out_ovf <= 1'b0;
        end else if (state == ADD && last) begin
            out_ovf <= low3_res[3] ^ nib_res[4];
        end
    end
`endif

endmodule
